// File: rtl/spi_ram_pkg.sv
// ----------------------------------------------------------------------------
// spi_ram_pkg
// Shared definitions for the SPI frame RAM controller and its SPI shifter:
//   - default geometry of the frame RAM (32 words x 24 bits)
//   - CRC-8 polynomial used by the shifter to produce rx_crc_ok
//   - controller FSM state encoding
// ----------------------------------------------------------------------------
package spi_ram_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_DEPTH  = 32;

    // x^8 + x^4 + x^3 + x^2 + 1, evaluated by the shifter, not by the controller
    localparam logic [7:0] CRC_POLY = 8'h1D;

    typedef enum logic [2:0] {
        ST_PREFETCH   = 3'd0,
        ST_RD_WAIT    = 3'd1,
        ST_READY      = 3'd2,
        ST_WRBACK     = 3'd3,
        ST_HOST_ISSUE = 3'd4,
        ST_HOST_WAIT  = 3'd5
    } state_t;

endpackage : spi_ram_pkg

// File: rtl/spi_ram_frame_ctrl.sv
// ----------------------------------------------------------------------------
// spi_ram_frame_ctrl
// Sequences a single-port synchronous frame RAM shared between an SPI slave
// shifter and a host register port. The word the next SPI frame transmits is
// prefetched into tx_data; a received word is written back only when its
// CRC-8 check passes, after which the wrapping frame pointer advances. Host
// accesses are granted only while no SPI frame is in flight.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   frame_start/done    synchronised 1-cycle frame events from the SCK domain
//   rx_data, rx_crc_ok  received word and its CRC verdict (with frame_done)
//   tx_data, tx_valid   word for the shifter; valid when it holds RAM[ptr]
//   frame_ptr           current frame address
//   underrun            sticky: a frame started while tx_valid was low
//   host_*              request/ack host port (req held until ack)
//   ram_*               RAM strobes/address/data; ram_rdata one cycle after
//                       a cs&oe cycle
//   crc_err_cnt         saturating CRC-failure count (optional, see below)
//
// Build option
//   SPI_RAM_FRAME_CTRL_ERRCNT_EN  adds crc_err_cnt[7:0]
// ----------------------------------------------------------------------------
module spi_ram_frame_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              frame_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_crc_ok,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic [ADDR_W-1:0] frame_ptr,
    output logic              underrun,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef SPI_RAM_FRAME_CTRL_ERRCNT_EN
    ,
    output logic [7:0]        crc_err_cnt
`endif
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                underrun_q, underrun_d;
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic                pend_crc_q, pend_crc_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic                host_ack_q, host_ack_d;
`ifdef SPI_RAM_FRAME_CTRL_ERRCNT_EN
    logic [7:0]          err_cnt_q, err_cnt_d;
`endif

    logic                done_v;
    logic                done_any;
    logic                crc_any;
    logic [ADDR_W-1:0]   ptr_next;

    // A frame_done outside an active frame is spurious and ignored.
    assign done_v   = frame_done && busy_q;
    // A live completion carries its own verdict; otherwise use the latched one.
    assign done_any = done_v || pend_q;
    assign crc_any  = done_v ? rx_crc_ok : pend_crc_q;
    assign ptr_next = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        ptr_d        = ptr_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        busy_d       = busy_q;
        underrun_d   = underrun_q;
        pend_d       = pend_q;
        pend_data_d  = pend_data_q;
        pend_crc_d   = pend_crc_q;
        host_rdata_d = host_rdata_q;
        host_ack_d   = 1'b0;
        ram_cs       = 1'b0;
        ram_we       = 1'b0;
        ram_oe       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;

        // Frame tracking runs in every state; the received word is always
        // captured so WRBACK writes it regardless of when it arrived.
        if (done_v) begin
            busy_d      = 1'b0;
            pend_data_d = rx_data;
            pend_crc_d  = rx_crc_ok;
        end
        if (frame_start) begin
            busy_d = 1'b1;
            if (!tx_valid_q) begin
                underrun_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_PREFETCH: begin
                ram_cs     = 1'b1;
                ram_oe     = 1'b1;
                ram_addr   = ptr_q;
                tx_valid_d = 1'b0;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                tx_data_d  = ram_rdata;
                tx_valid_d = 1'b1;
                state_d    = ST_READY;
            end
            ST_READY: begin
                if (done_any) begin
                    // A failed CRC stays here: same ptr, same tx_data, so the
                    // shifter retransmits the word on the next frame.
                    pend_d = 1'b0;
                    if (crc_any) begin
                        state_d = ST_WRBACK;
                    end
                end else if (host_req && !busy_q && !frame_start && !host_ack_q) begin
                    // host_ack_q blocks re-granting a request still held high
                    // in the cycle its acknowledge is visible.
                    state_d = ST_HOST_ISSUE;
                end
            end
            ST_WRBACK: begin
                ram_cs     = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = ptr_q;
                ram_wdata  = pend_data_q;
                ptr_d      = ptr_next;
                tx_valid_d = 1'b0;
                state_d    = ST_PREFETCH;
            end
            ST_HOST_ISSUE: begin
                ram_cs   = 1'b1;
                ram_addr = host_addr;
                if (host_we) begin
                    ram_we     = 1'b1;
                    ram_wdata  = host_wdata;
                    host_ack_d = 1'b1;
                    if (host_addr == ptr_q) begin
                        // The prefetched word was overwritten: fetch it again.
                        tx_valid_d = 1'b0;
                        state_d    = ST_PREFETCH;
                    end else begin
                        state_d = ST_READY;
                    end
                end else begin
                    ram_oe  = 1'b1;
                    state_d = ST_HOST_WAIT;
                end
            end
            ST_HOST_WAIT: begin
                host_rdata_d = ram_rdata;
                host_ack_d   = 1'b1;
                state_d      = ST_READY;
            end
            default: begin
                state_d = ST_PREFETCH;
            end
        endcase

        // Completions outside READY are remembered until READY is re-entered.
        if (done_v && (state_q != ST_READY)) begin
            pend_d = 1'b1;
        end

        // Keep the RAM idle while reset is held, even though the state
        // register already sits in PREFETCH.
        if (rst) begin
            ram_cs    = 1'b0;
            ram_we    = 1'b0;
            ram_oe    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

`ifdef SPI_RAM_FRAME_CTRL_ERRCNT_EN
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (done_v && !rx_crc_ok && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_PREFETCH;
            ptr_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            pend_crc_q   <= 1'b0;
            host_rdata_q <= '0;
            host_ack_q   <= 1'b0;
`ifdef SPI_RAM_FRAME_CTRL_ERRCNT_EN
            err_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            pend_crc_q   <= pend_crc_d;
            host_rdata_q <= host_rdata_d;
            host_ack_q   <= host_ack_d;
`ifdef SPI_RAM_FRAME_CTRL_ERRCNT_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign frame_ptr  = ptr_q;
    assign underrun   = underrun_q;
    assign host_rdata = host_rdata_q;
    assign host_ack   = host_ack_q;
`ifdef SPI_RAM_FRAME_CTRL_ERRCNT_EN
    assign crc_err_cnt = err_cnt_q;
`endif

endmodule : spi_ram_frame_ctrl

// File: tb/tb_spi_ram_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_ram_frame_ctrl
// Directed bench for spi_ram_frame_ctrl. A behavioural 32x24 synchronous RAM
// is attached to the RAM port. Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
// Build option SPI_RAM_FRAME_CTRL_ERRCNT_EN also exercises crc_err_cnt.
// ----------------------------------------------------------------------------
module tb_spi_ram_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, frame_done, rx_crc_ok;
    logic [23:0] rx_data;
    logic [23:0] tx_data;
    logic        tx_valid;
    logic [4:0]  frame_ptr;
    logic        underrun;
    logic        host_req, host_we;
    logic [4:0]  host_addr;
    logic [23:0] host_wdata, host_rdata;
    logic        host_ack;
    logic        ram_cs, ram_we, ram_oe;
    logic [4:0]  ram_addr;
    logic [23:0] ram_wdata, ram_rdata;
`ifdef SPI_RAM_FRAME_CTRL_ERRCNT_EN
    logic [7:0]  crc_err_cnt;
`endif

    logic [23:0] mem [32];
    int          wr_count = 0;
    logic        strobe_clash = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_ram_frame_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .rx_data     (rx_data),
        .rx_crc_ok   (rx_crc_ok),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .frame_ptr   (frame_ptr),
        .underrun    (underrun),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .host_ack    (host_ack),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_oe      (ram_oe),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
`ifdef SPI_RAM_FRAME_CTRL_ERRCNT_EN
        ,
        .crc_err_cnt (crc_err_cnt)
`endif
    );

    // Synchronous single-port frame RAM.
    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_count      <= wr_count + 1;
        end
        if (ram_cs && ram_oe) begin
            ram_rdata <= mem[ram_addr];
        end
        if (ram_we && ram_oe) begin
            strobe_clash <= 1'b1;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Full frame: start pulse, short gap, done pulse, then settle into READY.
    task automatic do_frame(input logic [23:0] d, input logic ok);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        cyc();
        rx_data    = d;
        rx_crc_ok  = ok;
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic wait_ack(input int limit, output int lat, output logic seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && (lat < limit)) begin
            cyc();
            lat++;
            if (host_ack === 1'b1) seen = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        logic seen;
        logic early;
        int   w0;

        for (int i = 0; i < 32; i++) mem[i] = 24'hC00000 + 24'(i);
        mem[0] = 24'h123456;

        rst         = 1'b1;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        rx_data     = '0;
        rx_crc_ok   = 1'b0;
        host_req    = 1'b0;
        host_we     = 1'b0;
        host_addr   = '0;
        host_wdata  = '0;
        repeat (3) cyc();

        // ---- reset state ----
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_ptr", frame_ptr, 0);
        check("rst_underrun", underrun, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_ram_cs", ram_cs, 0);
`ifdef SPI_RAM_FRAME_CTRL_ERRCNT_EN
        check("rst_errcnt", crc_err_cnt, 0);
`endif

        // ---- 1: prefetch latency after reset release ----
        rst = 1'b0;
        cyc();
        check("pf_lat1_valid", tx_valid, 0);
        cyc();
        check("pf_lat2_valid", tx_valid, 1);
        check("pf_tx_data", tx_data, 24'h123456);
        check("pf_ptr", frame_ptr, 0);

        // ---- 2: good frame writes back and advances ----
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        check("f1_no_underrun", underrun, 0);
        cyc();
        rx_data    = 24'hABCDEF;
        rx_crc_ok  = 1'b1;
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        check("wb_we", {ram_cs, ram_we, ram_oe}, 3'b110);
        check("wb_addr", ram_addr, 0);
        check("wb_wdata", ram_wdata, 24'hABCDEF);
        cyc();
        check("wb_valid_drop", tx_valid, 0);
        check("wb_ptr", frame_ptr, 1);
        check("wb_mem0", mem[0], 24'hABCDEF);
        cyc();
        cyc();
        check("wb_reprefetch_valid", tx_valid, 1);
        check("wb_reprefetch_data", tx_data, 24'hC00001);

        // ---- 3: CRC failure is a pure retry ----
        w0 = wr_count;
        do_frame(24'hDEAD00, 1'b0);
        check("crc_ptr", frame_ptr, 1);
        check("crc_tx_data", tx_data, 24'hC00001);
        check("crc_tx_valid", tx_valid, 1);
        check("crc_no_write", wr_count - w0, 0);
        check("crc_mem1", mem[1], 24'hC00001);
`ifdef SPI_RAM_FRAME_CTRL_ERRCNT_EN
        check("errcnt_1", crc_err_cnt, 1);
        for (int i = 0; i < 299; i++) do_frame(24'h0, 1'b0);
        check("errcnt_sat", crc_err_cnt, 255);
        check("errcnt_ptr", frame_ptr, 1);
`endif

        // ---- 4: host read while idle ----
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 5'd5;
        wait_ack(20, lat, seen);
        check("hrd_ack_seen", seen, 1);
        check("hrd_latency", lat, 3);
        check("hrd_rdata", host_rdata, 24'hC00005);
        host_req = 1'b0;
        cyc();
        check("hrd_ack_pulse", host_ack, 0);

        // ---- 4b: host blocked while a frame is active ----
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        host_req  = 1'b1;
        host_addr = 5'd2;
        early = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (host_ack === 1'b1) early = 1'b1;
        end
        check("busy_no_ack", early, 0);
        rx_data    = 24'h0B0B01;
        rx_crc_ok  = 1'b1;
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        wait_ack(20, lat, seen);
        check("busy_ack_seen", seen, 1);
        check("busy_rdata", host_rdata, 24'hC00002);
        check("busy_mem1", mem[1], 24'h0B0B01);
        check("busy_ptr", frame_ptr, 2);
        host_req = 1'b0;
        cyc();

        // ---- 5: frame_start and host_req together: frame wins ----
        frame_start = 1'b1;
        host_req    = 1'b1;
        host_we     = 1'b0;
        host_addr   = 5'd7;
        cyc();
        frame_start = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (host_ack === 1'b1) early = 1'b1;
        end
        check("race_no_ack", early, 0);
        rx_data    = 24'h0C0C02;
        rx_crc_ok  = 1'b1;
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        wait_ack(20, lat, seen);
        check("race_ack_seen", seen, 1);
        check("race_wb_first", mem[2], 24'h0C0C02);
        check("race_rdata", host_rdata, 24'hC00007);
        check("race_ptr", frame_ptr, 3);
        host_req = 1'b0;
        cyc();
        check("pre_hwr_tx_data", tx_data, 24'hC00003);

        // host write to the current pointer refreshes tx_data
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'd3;
        host_wdata = 24'h000777;
        wait_ack(20, lat, seen);
        check("hwr_ack_seen", seen, 1);
        check("hwr_latency", lat, 2);
        host_req = 1'b0;
        host_we  = 1'b0;
        check("hwr_valid_drop", tx_valid, 0);
        cyc();
        cyc();
        check("hwr_valid", tx_valid, 1);
        check("hwr_tx_data", tx_data, 24'h000777);

        // host write elsewhere leaves the prefetched word alone
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'd9;
        host_wdata = 24'h999999;
        wait_ack(20, lat, seen);
        check("hwr9_latency", lat, 2);
        host_req = 1'b0;
        host_we  = 1'b0;
        check("hwr9_mem", mem[9], 24'h999999);
        check("hwr9_valid", tx_valid, 1);
        check("hwr9_tx_data", tx_data, 24'h000777);
        cyc();

        // ---- 6: frame_start during PREFETCH sets sticky underrun ----
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        rx_data    = 24'h0D0D03;
        rx_crc_ok  = 1'b1;
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        cyc();
        check("ur_in_prefetch", tx_valid, 0);
        check("ur_before", underrun, 0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        check("ur_set", underrun, 1);
        cyc();
        check("ur_tx_data", tx_data, 24'hC00004);
        rx_data    = 24'h0E0E04;
        rx_crc_ok  = 1'b1;
        frame_done = 1'b1;
        cyc();
        frame_done = 1'b0;
        cyc();
        cyc();
        cyc();
        check("ur_ptr", frame_ptr, 5);
        check("ur_mem4", mem[4], 24'h0E0E04);

        // ---- 2b: pointer wrap ----
        for (int i = 5; i <= 30; i++) do_frame(24'h200000 + 24'(i), 1'b1);
        check("wrap_ptr31", frame_ptr, 31);
        check("wrap_mem30", mem[30], 24'h20001E);
        do_frame(24'h31F31F, 1'b1);
        check("wrap_ptr0", frame_ptr, 0);
        check("wrap_mem31", mem[31], 24'h31F31F);
        check("wrap_tx_data", tx_data, 24'hABCDEF);
        check("ur_sticky", underrun, 1);

        // ---- reset in the middle of a host read: no ack ----
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 5'd6;
        cyc();
        check("abort_issue_cs", {ram_cs, ram_oe}, 2'b11);
        rst      = 1'b1;
        host_req = 1'b0;
        cyc();
        check("abort_no_ack", host_ack, 0);
        check("abort_underrun", underrun, 0);
        check("abort_ptr", frame_ptr, 0);
        check("abort_cs", ram_cs, 0);
        cyc();
        check("abort_no_ack2", host_ack, 0);
        rst = 1'b0;
        cyc();
        cyc();
        check("rerst_valid", tx_valid, 1);
        check("rerst_tx_data", tx_data, 24'hABCDEF);

        check("we_oe_exclusive", strobe_clash, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_ram_frame_ctrl
